// File: rtl/gain_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : gain_stage_if
//  Description : Sample/control bundle for gain_stage.
//                master : upstream side, drives samples and gain controls,
//                         observes the scaled output and status.
//                slave  : gain_stage side.
//                gainIn/gainInValid    - signed input sample + qualifier
//                gainSet/gainLoad      - Q2.6 target gain + capture strobe
//                mute                  - forces effective target to zero
//                clipClear             - clears the sticky clip flag
//                gainOut/gainOutValid  - scaled, saturated sample + pulse
//                gainCur               - gain currently applied (Q2.6)
//                clip                  - sticky saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface gain_stage_if;
    logic signed [15:0] gainIn;
    logic               gainInValid;
    logic        [7:0]  gainSet;
    logic               gainLoad;
    logic               mute;
    logic               clipClear;
    logic signed [15:0] gainOut;
    logic               gainOutValid;
    logic        [7:0]  gainCur;
    logic               clip;

    modport master (
        output gainIn, gainInValid, gainSet, gainLoad, mute, clipClear,
        input  gainOut, gainOutValid, gainCur, clip
    );

    modport slave (
        input  gainIn, gainInValid, gainSet, gainLoad, mute, clipClear,
        output gainOut, gainOutValid, gainCur, clip
    );
endinterface
`default_nettype wire

// File: rtl/gain_stage.sv
`default_nettype none
// ============================================================================
//  Module      : gain_stage
//  Description : Two-stage signed x Q2.6 gain with saturation, sticky clip
//                flag and a sample-paced gain ramp toward a loadable target
//                (zero while muted).
//                clk     - single rising-edge clock
//                reset_n - synchronous, active-low reset
//                bus     - gain_stage_if.slave (samples, controls, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module gain_stage #(
    parameter int unsigned STEP = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    gain_stage_if.slave  bus
);

    localparam logic [1:0]         c_ST_IDLE = 2'd0;
    localparam logic [1:0]         c_ST_UP   = 2'd1;
    localparam logic [1:0]         c_ST_DOWN = 2'd2;
    localparam logic [7:0]         c_UNITY   = 8'd64;
    localparam logic [7:0]         c_STEP    = 8'(STEP);
    localparam logic signed [24:0] c_SAT_MAX = 25'sd32767;
    localparam logic signed [24:0] c_SAT_MIN = -25'sd32768;

    // Ramp control
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  w_dir;
    logic [7:0]  r_gain;
    logic [7:0]  w_gain_nxt;
    logic [7:0]  r_target;
    logic [7:0]  w_target_nxt;
    logic [7:0]  w_eff_target;
    logic [7:0]  w_dist;
    logic        r_step_pend;

    // Datapath
    logic signed [24:0] w_prod;
    logic signed [24:0] r_prod;
    logic               r_prod_vld;
    logic signed [24:0] w_shift;
    logic signed [15:0] w_sat;
    logic               w_sat_hit;
    logic signed [15:0] r_out;
    logic               r_out_vld;
    logic               r_clip;

    // r_state tracks gain vs. the stored target. Mute overrides the direction
    // live, so releasing mute falls straight back to the stored relation.
    always_comb begin
        w_eff_target = bus.mute ? 8'd0 : r_target;
        w_dir        = r_state;
        w_gain_nxt   = r_gain;
        w_dist       = 8'd0;

        if (bus.mute) begin
            w_dir = (r_gain == 8'd0) ? c_ST_IDLE : c_ST_DOWN;
        end

        // One step per accepted sample, taken on the following cycle
        if (r_step_pend) begin
            case (w_dir)
                c_ST_UP: begin
                    w_dist     = w_eff_target - r_gain;
                    w_gain_nxt = (w_dist <= c_STEP) ? w_eff_target : r_gain + c_STEP;
                end
                c_ST_DOWN: begin
                    w_dist     = r_gain - w_eff_target;
                    w_gain_nxt = (w_dist <= c_STEP) ? w_eff_target : r_gain - c_STEP;
                end
                default: ;
            endcase
        end

        w_target_nxt = bus.gainLoad ? bus.gainSet : r_target;

        if (w_gain_nxt < w_target_nxt) begin
            w_state_nxt = c_ST_UP;
        end else if (w_gain_nxt > w_target_nxt) begin
            w_state_nxt = c_ST_DOWN;
        end else begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_gain      <= c_UNITY;
            r_target    <= c_UNITY;
            r_step_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gain      <= w_gain_nxt;
            r_target    <= w_target_nxt;
            r_step_pend <= bus.gainInValid;
        end
    end

    // Gain is zero-extended so the multiply stays signed throughout
    assign w_prod = bus.gainIn * $signed({1'b0, r_gain});

    // Arithmetic shift floors toward -inf
    assign w_shift   = r_prod >>> 6;
    assign w_sat_hit = (w_shift > c_SAT_MAX) || (w_shift < c_SAT_MIN);
    assign w_sat     = (w_shift > c_SAT_MAX) ? 16'sh7FFF :
                       (w_shift < c_SAT_MIN) ? 16'sh8000 : w_shift[15:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            r_prod_vld <= bus.gainInValid;
            if (bus.gainInValid) begin
                r_prod <= w_prod;
            end
            r_out_vld <= r_prod_vld;
            if (r_prod_vld) begin
                r_out <= w_sat;
            end
            // A new saturation wins over a simultaneous clear
            if (r_prod_vld && w_sat_hit) begin
                r_clip <= 1'b1;
            end else if (bus.clipClear) begin
                r_clip <= 1'b0;
            end
        end
    end

    assign bus.gainOut      = r_out;
    assign bus.gainOutValid = r_out_vld;
    assign bus.gainCur      = r_gain;
    assign bus.clip         = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_gain_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gain_stage
//  Description : Directed self-checking bench for gain_stage with a
//                behavioural model (integer arithmetic plus an output queue)
//                compared every cycle, and literal expectations at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gain_stage;

    localparam int c_STEP = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    gain_stage_if bus();

    gain_stage #(.STEP(c_STEP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int val;
        bit sat;
    } ent_t;

    ent_t q[$];
    ent_t m_ent;
    int   cyc = 0;
    int   m_gain, m_tgt, m_out, m_eff, m_x, m_p;
    bit   m_pend, m_valid, m_clip, m_ready = 0, m_sat_now;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            m_gain  = 64;
            m_tgt   = 64;
            m_pend  = 0;
            q.delete();
            m_out   = 0;
            m_valid = 0;
            m_clip  = 0;
            m_ready = 1;
        end else begin
            m_valid   = 0;
            m_sat_now = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_ent     = q.pop_front();
                m_valid   = 1;
                m_out     = m_ent.val;
                m_sat_now = m_ent.sat;
            end
            if (m_sat_now)          m_clip = 1;
            else if (bus.clipClear) m_clip = 0;

            // sample uses the gain in force before this cycle's ramp step
            if (bus.gainInValid) begin
                m_x   = bus.gainIn;
                m_p   = (m_x * m_gain) >>> 6;
                m_ent.due = cyc + 1;
                m_ent.sat = (m_p > 32767) || (m_p < -32768);
                m_ent.val = (m_p > 32767) ? 32767 : (m_p < -32768) ? -32768 : m_p;
                q.push_back(m_ent);
            end

            if (m_pend) begin
                m_eff = bus.mute ? 0 : m_tgt;
                if (m_eff - m_gain > c_STEP)      m_gain = m_gain + c_STEP;
                else if (m_gain - m_eff > c_STEP) m_gain = m_gain - c_STEP;
                else                              m_gain = m_eff;
            end
            if (bus.gainLoad) m_tgt = bus.gainSet;
            m_pend = bus.gainInValid;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_ready) begin
            check("cyc_valid", 32'(bus.gainOutValid), 32'(m_valid));
            check("cyc_out",   bus.gainOut,           m_out);
            check("cyc_gain",  32'(bus.gainCur),      m_gain);
            check("cyc_clip",  32'(bus.clip),         32'(m_clip));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int x);
        bus.gainIn      = 16'(x);
        bus.gainInValid = 1'b1;
        @(negedge clk);
        bus.gainInValid = 1'b0;
    endtask

    task automatic send_chk(input string name, input int x, input int exp);
        send(x);
        @(negedge clk);
        check(name, bus.gainOut, exp);
        check({name, "_vld"}, 32'(bus.gainOutValid), 1);
    endtask

    task automatic load(input int g);
        bus.gainSet  = 8'(g);
        bus.gainLoad = 1'b1;
        @(negedge clk);
        bus.gainLoad = 1'b0;
    endtask

    task automatic burst(input int x, input int n);
        bus.gainIn      = 16'(x);
        bus.gainInValid = 1'b1;
        repeat (n) @(negedge clk);
        bus.gainInValid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.gainIn      = '0;
        bus.gainInValid = 1'b0;
        bus.gainSet     = '0;
        bus.gainLoad    = 1'b0;
        bus.mute        = 1'b0;
        bus.clipClear   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out",  bus.gainOut, 0);
        check("rst_vld",  32'(bus.gainOutValid), 0);
        check("rst_gain", 32'(bus.gainCur), 64);
        check("rst_clip", 32'(bus.clip), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // unity path
        send_chk("unity_pos", 1000, 1000);
        send_chk("unity_neg", -1000, -1000);
        @(negedge clk);
        check("unity_pulse", 32'(bus.gainOutValid), 0);

        // ramp 64 -> 128, one sample every 3 cycles
        load(128);
        for (int i = 1; i <= 18; i++) begin
            send(1000);
            @(negedge clk);
            if (i == 1)  check("ramp_s1", bus.gainOut, 1000);
            if (i == 2)  check("ramp_s2", bus.gainOut, 1062);
            if (i == 3)  check("ramp_s3", bus.gainOut, 1125);
            if (i >= 17) check("ramp_hold", bus.gainOut, 2000);
            @(negedge clk);
        end
        check("ramp_gain", 32'(bus.gainCur), 128);

        // floor rounding at gain 68
        do_reset();
        load(68);
        send_chk("floor_pre", 1000, 1000);
        check("floor_gain", 32'(bus.gainCur), 68);
        send_chk("floor", -1000, -1063);

        // saturation at gain 255
        load(255);
        burst(0, 50);
        repeat (2) @(negedge clk);
        check("sat_gain", 32'(bus.gainCur), 255);
        send_chk("sat_pos", 20000, 32767);
        check("sat_pos_clip", 32'(bus.clip), 1);
        bus.clipClear = 1'b1;
        @(negedge clk);
        bus.clipClear = 1'b0;
        check("clip_clear", 32'(bus.clip), 0);
        send_chk("sat_neg", -20000, -32768);
        check("sat_neg_clip", 32'(bus.clip), 1);
        send(20000);
        bus.clipClear = 1'b1;
        @(negedge clk);
        bus.clipClear = 1'b0;
        check("clip_race", 32'(bus.clip), 1);
        check("clip_race_out", bus.gainOut, 32767);
        send_chk("g255_small", 100, 398);
        check("clip_sticky", 32'(bus.clip), 1);
        bus.clipClear = 1'b1;
        @(negedge clk);
        bus.clipClear = 1'b0;
        check("clip_clear2", 32'(bus.clip), 0);

        // load coinciding with a sample: sample sees old gain
        bus.gainSet     = 8'd64;
        bus.gainLoad    = 1'b1;
        bus.gainIn      = 16'sd1000;
        bus.gainInValid = 1'b1;
        @(negedge clk);
        bus.gainLoad    = 1'b0;
        bus.gainInValid = 1'b0;
        @(negedge clk);
        check("load_same_out", bus.gainOut, 3984);
        check("load_same_gain", 32'(bus.gainCur), 251);
        repeat (3) @(negedge clk);

        // mute ramp down, load during mute, release
        do_reset();
        bus.mute = 1'b1;
        burst(1000, 16);
        repeat (2) @(negedge clk);
        check("mute_floor", 32'(bus.gainCur), 0);
        load(80);
        send_chk("mute_out", 1000, 0);
        check("mute_hold", 32'(bus.gainCur), 0);
        bus.mute = 1'b0;
        burst(1000, 22);
        repeat (2) @(negedge clk);
        check("unmute_gain", 32'(bus.gainCur), 80);
        check("unmute_out", bus.gainOut, 1250);

        // reset with a sample in flight
        send(1000);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check("rst_flush_vld", 32'(bus.gainOutValid), 0);
            @(negedge clk);
        end
        check("rst_flush_out", bus.gainOut, 0);
        check("rst_flush_gain", 32'(bus.gainCur), 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
